instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end of the RISC-V core. Owns the PC, issues word requests to instruction memory over a request/grant/response interface, buffers returned instructions in a small FIFO, and presents them with their PC and extracted 7-bit opcode to the decode stage (main controller and ALU controller) over a valid/ready handshake. Branch/jump resolution redirects it with a new PC, and it flushes all buffered and in-flight stale instructions.

## Interface
- XLEN, 32: address/instruction width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: instruction buffer entries (power of two, ≥2).
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered memory requests.

- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle (req & gnt).
- imem_rvalid  in  1  response valid; responses in request order, ≥1 cycle after grant.
- imem_rdata  in  XLEN  returned instruction.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts (transfer on valid & ready).
- id_instr  out  XLEN  instruction word.
- id_pc  out  XLEN  its address.
- id_opcode  out  7  id_instr[6:0].
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  XLEN  new fetch address.
- fetch_misalign  out  1  see Configuration.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_opcode=0, fetch_misalign=0; FIFO empty, outstanding=0, discard=0, state BOOT.
- FSM:
  - BOOT: one idle cycle after reset release → RUN.
  - RUN: imem_req=1 when outstanding + fifo_count < FIFO_DEPTH and outstanding < MAX_OUTSTANDING (registered values). On req & gnt: outstanding+1, fetch PC += 4 (wraps modulo 2^XLEN). On rvalid: outstanding−1, push {pc, rdata}; PC of each entry tracked by a response-PC register advanced by 4 per accepted response.
  - FLUSH: entered on redirect when outstanding (after this cycle's grant/response) is nonzero; discard ← that count; imem_req=0; each rvalid decrements discard and is dropped; discard reaching 0 → RUN.
- Redirect (any state except BOOT): FIFO cleared same edge regardless of id_ready; fetch PC and response PC ← redirect_pc; a grant in the redirect cycle counts as stale. If no stale responses, stays/returns to RUN and requests redirect_pc next cycle.
- Redirect during FLUSH: reload PC; discard continues counting remaining stale responses.
- Output: id_* is FIFO head; id_valid = FIFO non-empty. Simultaneous push and pop on full FIFO is legal only because issue credit guarantees no overflow; push on full is an assertion failure.
- imem_req, once raised, holds with stable imem_addr until gnt or redirect.

## Timing
- Reset release → imem_req=1 with addr RESET_PC at second rising edge.
- imem_rvalid at edge N → id_valid at N+1 (FIFO registered, no bypass).
- Zero-wait memory (gnt same cycle, rvalid next cycle) with id_ready=1: one instruction per cycle sustained.
- Redirect at edge N → imem_req for redirect_pc at N+1 if no stale; else after last stale rvalid.
- id_valid drops the cycle after redirect.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]≠0 sets fetch_misalign=1 (sticky until next aligned redirect or reset), FIFO flushed, no requests issued while set.
- Undefined: redirect_pc[1:0] forced to 0, fetch_misalign tied 0.

## Test plan
- Reset, RESET_PC=0x80 → second edge after release imem_req=1, imem_addr=0x80; id_valid=0 throughout.
- Zero-wait memory returning 0x00000013,0x00500093,0x00A00113, id_ready=1 → id_pc 0x80,0x84,0x88 on consecutive cycles, id_opcode=0x13.
- id_ready=0 for 8 cycles → FIFO reaches FIFO_DEPTH, imem_req=0, id_instr stable; release → all instructions delivered in order, none lost.
- Memory latency 3, two outstanding, redirect to 0x200 → both stale rvalids dropped, next id_pc=0x200.
- redirect concurrent with id_valid & id_ready and rvalid → FIFO empty next cycle, next delivered id_pc=redirect_pc.
- With IFETCH_MISALIGN_CHECK_EN, redirect_pc=0x202 → fetch_misalign=1, no imem_req; redirect 0x300 clears it and fetch resumes.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for instr_fetch_unit: imem request/grant/response, decode valid/ready, redirect.
// master = fetch unit side, slave = memory/decode/branch-resolution side.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [6:0]      id_opcode;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_misalign;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_instr, id_pc, id_opcode,
        input  id_ready,
        input  redirect, redirect_pc,
        output fetch_misalign
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_instr, id_pc, id_opcode,
        output id_ready,
        output redirect, redirect_pc,
        input  fetch_misalign
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// RISC-V instruction fetch front end: PC, credit-limited imem requests, response FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by defining IFETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    instr_fetch_unit_if.master  bus
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam int unsigned     DEPTH_U = FIFO_DEPTH;
    localparam logic [CW-1:0]   C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   C_MAXO  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]   C_ONE   = CW'(1);
    localparam logic [XLEN-1:0] C_STEP  = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic            r_misalign;
    logic [XLEN-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];

    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_redirect_bad;
    logic            w_issue;
    logic            w_ret;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_out_nxt;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign w_redirect_pc      = bus.redirect_pc;
    assign w_redirect_bad     = |bus.redirect_pc[1:0];
    assign bus.fetch_misalign = r_misalign;
`else
    assign w_redirect_pc      = bus.redirect_pc & ~XLEN'(3);
    assign w_redirect_bad     = 1'b0;
    assign bus.fetch_misalign = 1'b0;
`endif

    assign w_redirect = bus.redirect && (r_state != S_BOOT);
    assign w_issue    = bus.imem_req && bus.imem_gnt;
    assign w_ret      = bus.imem_rvalid;
    // A grant in the redirect cycle is already in flight, so it is counted as stale.
    assign w_out_nxt  = r_outstanding + CW'(w_issue) - CW'(w_ret);
    assign w_push     = w_ret && (r_state == S_RUN) && !w_redirect;
    assign w_pop      = (r_count != '0) && bus.id_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (w_redirect && (w_out_nxt != '0)) w_state_nxt = S_FLUSH;
            S_FLUSH: begin
                if (w_redirect) begin
                    if (w_out_nxt == '0) w_state_nxt = S_RUN;
                end else if (w_ret && (r_discard == C_ONE)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        bus.imem_req = 1'b0;
        if ((r_state == S_RUN) && !r_misalign &&
            ((r_outstanding + r_count) < C_DEPTH) && (r_outstanding < C_MAXO)) begin
            bus.imem_req = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_misalign    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_outstanding <= w_out_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_misalign <= w_redirect_bad;
                r_discard  <= w_out_nxt;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + C_STEP;
                end
                if ((r_state == S_FLUSH) && w_ret) begin
                    r_discard <= r_discard - C_ONE;
                end
                if (w_push) begin
                    r_fifo_instr[r_wptr] <= bus.imem_rdata;
                    r_fifo_pc[r_wptr]    <= r_resp_pc;
                    r_wptr               <= r_wptr + 1'b1;
                    r_resp_pc            <= r_resp_pc + C_STEP;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    assign bus.imem_addr = r_fetch_pc;
    assign bus.id_valid  = (r_count != '0);
    assign bus.id_instr  = r_fifo_instr[r_rptr];
    assign bus.id_pc     = r_fifo_pc[r_rptr];
    assign bus.id_opcode = r_fifo_instr[r_rptr][6:0];

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && (r_count == C_DEPTH)));

    a_req_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.imem_req && !bus.imem_gnt && !w_redirect) |=> (bus.imem_req && $stable(bus.imem_addr)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_instr_fetch_unit;
    localparam int XLEN = 32;

    logic clk;
    logic reset_n;

    instr_fetch_unit_if #(.XLEN(XLEN)) ifc ();

    instr_fetch_unit #(
        .XLEN(XLEN),
        .RESET_PC(32'h0000_0080),
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(ifc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];
    int    mcyc;
    int    mem_lat;
    bit    gnt_en;
    int    n_vec;
    int    n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0080: return 32'h0000_0013;
            32'h0000_0084: return 32'h0050_0093;
            32'h0000_0088: return 32'h00A0_0113;
            default:       return {a[24:0], 7'h33};
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, limit 100000", $time);
        $fatal(1);
    end

    // Memory acts 1 time unit after each falling edge, after the test tasks have driven.
    initial begin
        mcyc = 0;
        ifc.imem_gnt    = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            mcyc++;
            ifc.imem_gnt    = 1'b0;
            ifc.imem_rvalid = 1'b0;
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                ifc.imem_rvalid = 1'b1;
                ifc.imem_rdata  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end
            if (gnt_en && ifc.imem_req === 1'b1) begin
                ifc.imem_gnt = 1'b1;
                mq.push_back('{addr: ifc.imem_addr, due: mcyc + mem_lat});
            end
        end
    end

    task automatic quiesce();
        bit done;
        done = 1'b0;
        gnt_en = 1'b0;
        ifc.redirect = 1'b0;
        ifc.id_ready = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && ifc.id_valid === 1'b0) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL quiesce: busy=1 after 30 cycles, required busy=0");
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ifc.id_ready = 1'b0;
        ifc.redirect = 1'b0;
        ifc.redirect_pc = '0;
        gnt_en = 1'b0;
        mem_lat = 1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.id_valid, ifc.fetch_misalign} !== {1'b0, 32'h80, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_ctrl: req/addr/valid/mis=%b/%h/%b/%b required 0/00000080/0/0",
                     ifc.imem_req, ifc.imem_addr, ifc.id_valid, ifc.fetch_misalign);
        end
        n_vec++;
        if ({ifc.id_instr, ifc.id_pc, ifc.id_opcode} !== {32'h0, 32'h0, 7'h0}) begin
            n_err++;
            $display("FAIL reset_id: instr/pc/op=%h/%h/%h required 0/0/0", ifc.id_instr, ifc.id_pc, ifc.id_opcode);
        end
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (ifc.imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL boot_idle: req=%b required 0", ifc.imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ifc.imem_req, ifc.imem_addr, ifc.id_valid} !== {1'b1, 32'h80, 1'b0}) begin
                n_err++;
                $display("FAIL first_req[%0d]: req/addr/valid=%b/%h/%b required 1/00000080/0",
                         i, ifc.imem_req, ifc.imem_addr, ifc.id_valid);
            end
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        ifc.id_ready = 1'b1;
        mem_lat = 1;
        gnt_en = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ifc.id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_latency: id_valid=%b required 0", ifc.id_valid);
        end
        exp_pc = 32'h80;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ifc.id_valid, ifc.id_pc, ifc.id_instr, ifc.id_opcode} !==
                {1'b1, exp_pc, mem_word(exp_pc), 7'h13 ^ ((i == 3) ? 7'h20 : 7'h00)}) begin
                n_err++;
                $display("FAIL stream[%0d]: valid/pc/instr/op=%b/%h/%h/%h required 1/%h/%h/%h", i,
                         ifc.id_valid, ifc.id_pc, ifc.id_instr, ifc.id_opcode,
                         exp_pc, mem_word(exp_pc), 7'h13 ^ ((i == 3) ? 7'h20 : 7'h00));
            end
            exp_pc = exp_pc + 32'h4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        ifc.id_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ifc.id_valid, ifc.id_pc, ifc.id_instr} !== {1'b1, 32'h8C, mem_word(32'h8C)}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: valid/pc/instr=%b/%h/%h required 1/0000008c/%h",
                         i, ifc.id_valid, ifc.id_pc, ifc.id_instr, mem_word(32'h8C));
            end
        end
        n_vec++;
        if (ifc.imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL stall_full_req: req=%b required 0", ifc.imem_req);
        end
        ifc.id_ready = 1'b1;
        exp_pc = 32'h90;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ifc.id_valid, ifc.id_pc, ifc.id_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
                n_err++;
                $display("FAIL drain[%0d]: valid/pc/instr=%b/%h/%h required 1/%h/%h",
                         i, ifc.id_valid, ifc.id_pc, ifc.id_instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'h4;
        end
    endtask

    task automatic test_redirect_stale(input bit second_redirect);
        logic [31:0] tgt;
        tgt = second_redirect ? 32'h280 : 32'h200;
        quiesce();
        mem_lat = 3;
        gnt_en = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (ifc.imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL max_outstanding_req: req=%b required 0", ifc.imem_req);
        end
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h200;
        @(negedge clk);
        ifc.redirect = second_redirect;
        ifc.redirect_pc = 32'h280;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({ifc.imem_req, ifc.id_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL flush_quiet[%0d]: req/valid=%b/%b required 0/0", i, ifc.imem_req, ifc.id_valid);
            end
            @(negedge clk);
            ifc.redirect = 1'b0;
        end
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.id_valid} !== {1'b1, tgt, 1'b0}) begin
            n_err++;
            $display("FAIL refetch_req: req/addr/valid=%b/%h/%b required 1/%h/0",
                     ifc.imem_req, ifc.imem_addr, ifc.id_valid, tgt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (ifc.id_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stale_dropped[%0d]: id_valid=%b required 0", i, ifc.id_valid);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({ifc.id_valid, ifc.id_pc, ifc.id_instr} !== {1'b1, tgt, mem_word(tgt)}) begin
            n_err++;
            $display("FAIL redirect_first: valid/pc/instr=%b/%h/%h required 1/%h/%h",
                     ifc.id_valid, ifc.id_pc, ifc.id_instr, tgt, mem_word(tgt));
        end
    endtask

    task automatic test_redirect_concurrent();
        quiesce();
        mem_lat = 1;
        gnt_en = 1'b1;
        repeat (4) @(negedge clk);
        n_vec++;
        if ({ifc.id_valid, ifc.imem_req} !== 2'b11) begin
            n_err++;
            $display("FAIL conc_pre: valid/req=%b/%b required 1/1", ifc.id_valid, ifc.imem_req);
        end
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h400;
        @(negedge clk);
        ifc.redirect = 1'b0;
        n_vec++;
        if ({ifc.id_valid, ifc.imem_req} !== 2'b00) begin
            n_err++;
            $display("FAIL conc_flush: valid/req=%b/%b required 0/0", ifc.id_valid, ifc.imem_req);
        end
        @(negedge clk);
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.id_valid} !== {1'b1, 32'h400, 1'b0}) begin
            n_err++;
            $display("FAIL conc_refetch: req/addr/valid=%b/%h/%b required 1/00000400/0",
                     ifc.imem_req, ifc.imem_addr, ifc.id_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ifc.id_valid, ifc.id_pc} !== {1'b1, 32'h400 + 32'(4 * i)}) begin
                n_err++;
                $display("FAIL conc_deliver[%0d]: valid/pc=%b/%h required 1/%h",
                         i, ifc.id_valid, ifc.id_pc, 32'h400 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_pc_wrap();
        quiesce();
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        ifc.redirect = 1'b0;
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL wrap_req: req/addr=%b/%h required 1/fffffffc", ifc.imem_req, ifc.imem_addr);
        end
        mem_lat = 1;
        gnt_en = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL wrap_addr: req/addr=%b/%h required 1/00000000", ifc.imem_req, ifc.imem_addr);
        end
        @(negedge clk);
        n_vec++;
        if ({ifc.id_valid, ifc.id_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL wrap_pc0: valid/pc=%b/%h required 1/fffffffc", ifc.id_valid, ifc.id_pc);
        end
        @(negedge clk);
        n_vec++;
        if ({ifc.id_valid, ifc.id_pc, ifc.id_instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            n_err++;
            $display("FAIL wrap_pc1: valid/pc/instr=%b/%h/%h required 1/00000000/%h",
                     ifc.id_valid, ifc.id_pc, ifc.id_instr, mem_word(32'h0));
        end
    endtask

    task automatic test_misalign();
        quiesce();
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h202;
        @(negedge clk);
        ifc.redirect = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({ifc.fetch_misalign, ifc.imem_req, ifc.id_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL misalign_set[%0d]: mis/req/valid=%b/%b/%b required 1/0/0",
                         i, ifc.fetch_misalign, ifc.imem_req, ifc.id_valid);
            end
            if (i < 2) @(negedge clk);
        end
        ifc.redirect = 1'b1;
        ifc.redirect_pc = 32'h300;
        @(negedge clk);
        ifc.redirect = 1'b0;
        n_vec++;
        if ({ifc.fetch_misalign, ifc.imem_req, ifc.imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            n_err++;
            $display("FAIL misalign_clear: mis/req/addr=%b/%b/%h required 0/1/00000300",
                     ifc.fetch_misalign, ifc.imem_req, ifc.imem_addr);
        end
        mem_lat = 1;
        gnt_en = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ifc.id_valid, ifc.id_pc} !== {1'b1, 32'h300}) begin
            n_err++;
            $display("FAIL misalign_resume: valid/pc=%b/%h required 1/00000300", ifc.id_valid, ifc.id_pc);
        end
`else
        n_vec++;
        if ({ifc.fetch_misalign, ifc.imem_req, ifc.imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            n_err++;
            $display("FAIL misalign_forced: mis/req/addr=%b/%b/%h required 0/1/00000200",
                     ifc.fetch_misalign, ifc.imem_req, ifc.imem_addr);
        end
        mem_lat = 1;
        gnt_en = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ifc.id_valid, ifc.id_pc, ifc.fetch_misalign} !== {1'b1, 32'h200, 1'b0}) begin
            n_err++;
            $display("FAIL misalign_deliver: valid/pc/mis=%b/%h/%b required 1/00000200/0",
                     ifc.id_valid, ifc.id_pc, ifc.fetch_misalign);
        end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale(1'b0);
        test_redirect_stale(1'b1);
        test_redirect_concurrent();
        test_pc_wrap();
        test_misalign();
        quiesce();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
